// File: rtl/serdes_pkg.sv
// Shared definitions for the serdes virtual-channel link: beat kinds, beat
// field offsets and error-cause bit positions.
package serdes_pkg;

    typedef enum logic [2:0] {
        KIND_IDLE = 3'd0,
        KIND_AR   = 3'd1,
        KIND_AW   = 3'd2,
        KIND_W    = 3'd3,
        KIND_R    = 3'd4,
        KIND_B    = 3'd5
    } kind_e;

    localparam int KIND_BITS = 3;
    localparam int KIND_LSB  = 0;
    localparam int VC_LSB    = 3;

    // Bit positions of the individual causes folded into the sticky err flag.
    localparam int ERR_CREDIT_OVF = 0;
    localparam int ERR_FIFO_OVF   = 1;
    localparam int ERR_BAD_VC     = 2;
    localparam int ERR_ZERO_KIND  = 3;
    localparam int ERR_CAUSES     = 4;

endpackage

// File: rtl/serdes_link_vc_if.sv
// Per-VC transmit and receive stream bundle between the protocol converters
// (master side) and the serdes link endpoint (slave side).
interface serdes_link_vc_if #(
    parameter int NCH = 4,
    parameter int PW  = 67
);
    logic [NCH-1:0]    tx_valid;
    logic [NCH-1:0]    tx_ready;
    logic [3*NCH-1:0]  tx_kind;
    logic [PW*NCH-1:0] tx_data;
    logic [NCH-1:0]    rx_valid;
    logic [NCH-1:0]    rx_ready;
    logic [3*NCH-1:0]  rx_kind;
    logic [PW*NCH-1:0] rx_data;

    modport master (
        output tx_valid, tx_kind, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_kind, rx_data
    );

    modport slave (
        input  tx_valid, tx_kind, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_kind, rx_data
    );
endinterface

// File: rtl/serdes_link_vc_fifo.sv
// Synchronous FIFO with a combinational head; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module syncfifo_sampled #(
    parameter int WID   = 70,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [WID-1:0] din,
    input  logic           pop,
    output logic [WID-1:0] dout,
    output logic           empty,
    output logic           full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WID-1:0] mem_q [DEPTH];
    logic           do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        dout = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/serdes_link_vc.sv
// Multiplexes NCH credit-flow-controlled virtual channels onto one serdes
// beat bus and demultiplexes the incoming bus into per-VC receive FIFOs.
module serdes_link_vc
    import serdes_pkg::*;
#(
    parameter int WBUS    = 72,
    parameter int NCH     = 4,
    parameter int CREDITS = 8,
    parameter int CHW     = $clog2(NCH),
    parameter int PW      = WBUS - KIND_BITS - CHW
) (
    input  logic            clk,
    input  logic            rst_n,
    serdes_link_vc_if.slave vc_bus,
    output logic [WBUS-1:0] outgoing,
    input  logic [NCH-1:0]  credit_in,
    input  logic [WBUS-1:0] incoming,
    output logic [NCH-1:0]  credit_out,
    output logic            err
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int FW = PW + KIND_BITS;

    logic [KIND_BITS-1:0] tx_kind_a [NCH];
    logic [PW-1:0]        tx_data_a [NCH];

    logic [CW-1:0]   credit_q [NCH];
    logic [CW-1:0]   credit_d [NCH];
    logic [CHW-1:0]  last_grant_q, last_grant_d;
    logic [WBUS-1:0] out_q, out_d;
    logic [NCH-1:0]  credit_out_q, credit_out_d;
    logic            err_q, err_d;

    logic [NCH-1:0]   eligible, tx_ready, send, credit_ovf, zero_kind;
    logic [2*NCH-1:0] elig2;
    logic [NCH-1:0]   rot;
    logic [CHW-1:0]   start, pick, grant;
    logic [CHW:0]     sum;
    logic             found;

    logic [KIND_BITS-1:0] in_kind;
    logic [CHW-1:0]       in_vc;
    logic [PW-1:0]        in_payload;
    logic                 in_valid, bad_vc;
    logic [NCH-1:0]       push, pop, fifo_empty, fifo_full;
    logic [FW-1:0]        fifo_dout [NCH];
    logic [3*NCH-1:0]     rx_kind_v;
    logic [PW*NCH-1:0]    rx_data_v;
    logic [ERR_CAUSES-1:0] err_cause;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            tx_kind_a[i] = vc_bus.tx_kind[i*KIND_BITS +: KIND_BITS];
            tx_data_a[i] = vc_bus.tx_data[i*PW +: PW];
            eligible[i]  = vc_bus.tx_valid[i] && (credit_q[i] != '0);
            zero_kind[i] = vc_bus.tx_valid[i] && (tx_kind_a[i] == KIND_IDLE);
        end
    end

    // Round-robin: rotate so the VC after last_grant sits at bit 0, take the
    // lowest set bit, then add the rotation back modulo NCH.
    always_comb begin
        start = (last_grant_q == CHW'(NCH - 1)) ? '0 : last_grant_q + CHW'(1);
        elig2 = {eligible, eligible};
        rot   = elig2[start +: NCH];
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (rot[k] && !found) begin
                found = 1'b1;
                pick  = CHW'(k);
            end
        end
        sum = {1'b0, pick} + {1'b0, start};
        if (sum >= (CHW+1)'(NCH)) begin
            sum = sum - (CHW+1)'(NCH);
        end
        grant    = sum[CHW-1:0];
        tx_ready = found ? (NCH'(1) << grant) : '0;
        send     = vc_bus.tx_valid & tx_ready;
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            credit_d[i]   = credit_q[i];
            credit_ovf[i] = 1'b0;
            case ({send[i], credit_in[i]})
                2'b10: credit_d[i] = credit_q[i] - CW'(1);
                2'b01: begin
                    if (credit_q[i] == CW'(CREDITS)) begin
                        credit_ovf[i] = 1'b1;
                    end else begin
                        credit_d[i] = credit_q[i] + CW'(1);
                    end
                end
                default: credit_d[i] = credit_q[i];
            endcase
        end
    end

    always_comb begin
        out_d = out_q;
        out_d[KIND_LSB +: KIND_BITS] = '0;
        last_grant_d = last_grant_q;
        if (|send) begin
            out_d        = {tx_data_a[grant], grant, tx_kind_a[grant]};
            last_grant_d = grant;
        end
    end

    always_comb begin
        in_kind    = incoming[KIND_LSB +: KIND_BITS];
        in_vc      = incoming[VC_LSB +: CHW];
        in_payload = incoming[WBUS-1 -: PW];
        in_valid   = (in_kind != KIND_IDLE);
        bad_vc     = in_valid && ({1'b0, in_vc} >= (CHW+1)'(NCH));
        for (int unsigned i = 0; i < NCH; i++) begin
            push[i] = in_valid && !bad_vc && (in_vc == CHW'(i));
        end
        pop          = ~fifo_empty & vc_bus.rx_ready;
        credit_out_d = pop;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_rx
        syncfifo_sampled #(
            .WID   (FW),
            .DEPTH (CREDITS)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .din   ({in_payload, in_kind}),
            .pop   (pop[g]),
            .dout  (fifo_dout[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full[g])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            rx_kind_v[i*KIND_BITS +: KIND_BITS] = fifo_dout[i][KIND_BITS-1:0];
            rx_data_v[i*PW +: PW]               = fifo_dout[i][FW-1:KIND_BITS];
        end
        err_cause                 = '0;
        err_cause[ERR_CREDIT_OVF] = |credit_ovf;
        err_cause[ERR_FIFO_OVF]   = |(push & fifo_full & ~pop);
        err_cause[ERR_BAD_VC]     = bad_vc;
        err_cause[ERR_ZERO_KIND]  = |zero_kind;
        err_d                     = err_q | (|err_cause);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                credit_q[i] <= CW'(CREDITS);
            end
            last_grant_q <= CHW'(NCH - 1);
            out_q        <= '0;
            credit_out_q <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                credit_q[i] <= credit_d[i];
            end
            last_grant_q <= last_grant_d;
            out_q        <= out_d;
            credit_out_q <= credit_out_d;
            err_q        <= err_d;
        end
    end

    assign vc_bus.tx_ready = tx_ready;
    assign vc_bus.rx_valid = ~fifo_empty;
    assign vc_bus.rx_kind  = rx_kind_v;
    assign vc_bus.rx_data  = rx_data_v;
    assign outgoing        = out_q;
    assign credit_out      = credit_out_q;
    assign err             = err_q;

endmodule

// File: tb/tb_serdes_link_vc.sv
// Bench for serdes_link_vc: looped-back random traffic against a queue-based
// link model, followed by directed credit, buffering and error scenarios.
module tb_serdes_link_vc;
    import serdes_pkg::*;

    localparam int WBUS    = 72;
    localparam int NCH     = 4;
    localparam int CREDITS = 8;
    localparam int CHW     = 2;
    localparam int PW      = WBUS - 3 - CHW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serdes_link_vc_if #(.NCH(NCH), .PW(PW)) vc_bus ();

    logic [WBUS-1:0] outgoing, incoming, inc_drv;
    logic [NCH-1:0]  credit_in, credit_out, cin_drv;
    logic            err, loop_en;

    assign incoming  = loop_en ? outgoing : inc_drv;
    assign credit_in = loop_en ? credit_out : cin_drv;

    serdes_link_vc #(
        .WBUS    (WBUS),
        .NCH     (NCH),
        .CREDITS (CREDITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vc_bus     (vc_bus),
        .outgoing   (outgoing),
        .credit_in  (credit_in),
        .incoming   (incoming),
        .credit_out (credit_out),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [WBUS-1:0] got, input logic [WBUS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the looped-back link: credit counters, round-robin
    // pointer and per-VC in-flight queues tagged with the cycle they become visible.
    typedef struct {
        int         t;
        logic [2:0] kind;
        logic [PW-1:0] data;
    } rxe_t;

    rxe_t            rxq [NCH][$];
    int              m_credit [NCH];
    int              m_last;
    int              cyc;
    logic [WBUS-1:0] exp_out;
    logic            exp_busy;
    logic [NCH-1:0]  exp_cout;
    bit              mon_en = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_credit[i] = CREDITS;
            rxq[i].delete();
        end
        m_last   = NCH - 1;
        cyc      = 0;
        exp_busy = 1'b0;
        exp_cout = '0;
    endtask

    always @(negedge clk) begin
        int g, v;
        logic [NCH-1:0] exp_rdy, next_cout;
        logic av;
        if (mon_en) begin
            if (exp_busy) chk("outgoing_beat", outgoing, exp_out);
            else          chk("outgoing_idle_kind", WBUS'(outgoing[2:0]), '0);
            chk("credit_out", WBUS'(credit_out), WBUS'(exp_cout));
            chk("err_clean", WBUS'(err), '0);

            g = -1;
            for (int k = 1; k <= NCH; k++) begin
                v = (m_last + k) % NCH;
                if (g < 0 && vc_bus.tx_valid[v] && m_credit[v] > 0) g = v;
            end
            exp_rdy = (g >= 0) ? (NCH'(1) << g) : '0;
            chk("tx_ready", WBUS'(vc_bus.tx_ready), WBUS'(exp_rdy));

            next_cout = '0;
            for (int i = 0; i < NCH; i++) begin
                av = (rxq[i].size() > 0) && (rxq[i][0].t <= cyc);
                chk("rx_valid", WBUS'(vc_bus.rx_valid[i]), WBUS'(av));
                if (av && vc_bus.rx_ready[i]) begin
                    chk("rx_kind", WBUS'(vc_bus.rx_kind[i*3 +: 3]), WBUS'(rxq[i][0].kind));
                    chk("rx_data", WBUS'(vc_bus.rx_data[i*PW +: PW]), WBUS'(rxq[i][0].data));
                    void'(rxq[i].pop_front());
                    next_cout[i] = 1'b1;
                end
                m_credit[i] += int'(exp_cout[i]);
            end

            if (g >= 0) begin
                m_credit[g]--;
                m_last = g;
                rxq[g].push_back('{t: cyc + 2, kind: vc_bus.tx_kind[g*3 +: 3],
                                   data: vc_bus.tx_data[g*PW +: PW]});
                exp_out  = {vc_bus.tx_data[g*PW +: PW], CHW'(g), vc_bus.tx_kind[g*3 +: 3]};
                exp_busy = 1'b1;
            end else begin
                exp_busy = 1'b0;
            end
            exp_cout = next_cout;
            cyc++;
        end
    end

    task automatic drive_rand(input logic [NCH-1:0] v, input logic [NCH-1:0] r);
        vc_bus.tx_valid = v;
        vc_bus.rx_ready = r;
        for (int i = 0; i < NCH; i++) begin
            vc_bus.tx_kind[i*3 +: 3]  = 3'($urandom_range(1, 5));
            vc_bus.tx_data[i*PW +: PW] = PW'({$urandom(), $urandom(), $urandom()});
        end
    endtask

    task automatic count_sends(input int ncyc, input int v, output int n);
        n = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (vc_bus.tx_valid[v] && vc_bus.tx_ready[v]) n++;
            step();
        end
    endtask

    task automatic make_beat(input int v, output logic [WBUS-1:0] b, output logic [PW+2:0] e);
        logic [2:0]    k;
        logic [PW-1:0] d;
        k = 3'($urandom_range(1, 5));
        d = PW'({$urandom(), $urandom(), $urandom()});
        b = {d, CHW'(v), k};
        e = {d, k};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, pulses;
        logic [WBUS-1:0] b;
        logic [PW+2:0]   e;
        logic [PW+2:0]   expq [$];

        loop_en = 1'b1;
        inc_drv = '0;
        cin_drv = '0;
        vc_bus.tx_valid = '0;
        vc_bus.tx_kind  = '0;
        vc_bus.tx_data  = '0;
        vc_bus.rx_ready = '0;
        rst_n = 1'b0;
        #12;
        chk("reset_outgoing", outgoing, '0);
        chk("reset_credit_out", WBUS'(credit_out), '0);
        chk("reset_rx_valid", WBUS'(vc_bus.rx_valid), '0);
        chk("reset_err", WBUS'(err), '0);
        repeat (2) step();
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // All VCs offered with immediate pop: strict 0,1,2,3 rotation.
        repeat (40) begin drive_rand('1, '1); step(); end
        // Sparse then dense receive pops force credit stalls and recovery.
        repeat (700) begin drive_rand(NCH'($urandom()), NCH'($urandom() & $urandom())); step(); end
        repeat (700) begin drive_rand(NCH'($urandom()), NCH'($urandom() | $urandom())); step(); end
        repeat (30) begin drive_rand('0, '1); step(); end
        mon_en = 1'b0;

        // Asynchronous reset in the middle of traffic.
        repeat (6) begin drive_rand('1, '0); step(); end
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_outgoing", outgoing, '0);
        chk("midreset_credit_out", WBUS'(credit_out), '0);
        chk("midreset_rx_valid", WBUS'(vc_bus.rx_valid), '0);
        chk("midreset_err", WBUS'(err), '0);
        vc_bus.tx_valid = '0;
        step();
        rst_n = 1'b1;

        // Credit exhaustion on VC1, then a single returned credit.
        loop_en = 1'b0;
        drive_rand(4'b0010, '0);
        count_sends(12, 1, n);
        chk("exhaust_sends", WBUS'(n), WBUS'(CREDITS));
        @(negedge clk);
        chk("exhaust_ready_low", WBUS'(vc_bus.tx_ready[1]), '0);
        step();
        cin_drv = 4'b0010;
        @(negedge clk);
        chk("ready_during_credit_in", WBUS'(vc_bus.tx_ready[1]), '0);
        step();
        cin_drv = '0;
        @(negedge clk);
        chk("ready_after_credit_in", WBUS'(vc_bus.tx_ready[1]), 1);
        step();
        count_sends(6, 1, n);
        chk("one_more_send_only", WBUS'(n), '0);

        // Credit return while VC0 already holds full credit.
        vc_bus.tx_valid = '0;
        cin_drv = 4'b0001;
        @(negedge clk);
        chk("err_before_overflow", WBUS'(err), '0);
        step();
        cin_drv = '0;
        @(negedge clk);
        chk("err_credit_overflow", WBUS'(err), 1);
        step();
        vc_bus.tx_valid = 4'b0001;
        count_sends(14, 0, n);
        chk("overflow_credit_saturated", WBUS'(n), WBUS'(CREDITS));

        // Receive buffering, push+pop on a full FIFO, overflow drop, drain.
        vc_bus.tx_valid = '0;
        do_reset();
        pulses = 0;
        for (int j = 0; j < CREDITS; j++) begin
            make_beat(2, b, e);
            inc_drv = b;
            expq.push_back(e);
            @(negedge clk);
            pulses += int'(|credit_out);
            step();
        end
        inc_drv = '0;
        @(negedge clk);
        pulses += int'(|credit_out);
        chk("rx_valid_buffered", WBUS'(vc_bus.rx_valid), WBUS'(4'b0100));
        chk("no_credit_out_buffered", WBUS'(pulses), '0);
        chk("err_after_fill", WBUS'(err), '0);
        step();
        make_beat(2, b, e);
        inc_drv = b;
        vc_bus.rx_ready = 4'b0100;
        @(negedge clk);
        chk("full_pushpop_head", WBUS'({vc_bus.rx_data[2*PW +: PW], vc_bus.rx_kind[6 +: 3]}), WBUS'(expq[0]));
        void'(expq.pop_front());
        expq.push_back(e);
        step();
        inc_drv = '0;
        vc_bus.rx_ready = '0;
        @(negedge clk);
        chk("err_after_full_pushpop", WBUS'(err), '0);
        chk("credit_out_after_pushpop", WBUS'(credit_out), WBUS'(4'b0100));
        step();
        make_beat(2, b, e);
        inc_drv = b;
        step();
        inc_drv = '0;
        @(negedge clk);
        chk("err_fifo_overflow", WBUS'(err), 1);
        step();
        vc_bus.rx_ready = 4'b0100;
        for (int j = 0; j < CREDITS; j++) begin
            @(negedge clk);
            chk("drain_rx_valid", WBUS'(vc_bus.rx_valid[2]), 1);
            chk("drain_head", WBUS'({vc_bus.rx_data[2*PW +: PW], vc_bus.rx_kind[6 +: 3]}), WBUS'(expq[0]));
            chk("drain_credit_out", WBUS'(credit_out), (j > 0) ? WBUS'(4'b0100) : '0);
            void'(expq.pop_front());
            step();
        end
        vc_bus.rx_ready = '0;
        @(negedge clk);
        chk("drain_last_credit_out", WBUS'(credit_out), WBUS'(4'b0100));
        chk("drain_empty", WBUS'(vc_bus.rx_valid), '0);
        step();

        // Zero-kind beat is still sent but flags an error.
        do_reset();
        vc_bus.tx_valid = 4'b0001;
        vc_bus.tx_kind  = '0;
        @(negedge clk);
        chk("zero_kind_accepted", WBUS'(vc_bus.tx_ready), WBUS'(4'b0001));
        step();
        vc_bus.tx_valid = '0;
        @(negedge clk);
        chk("err_zero_kind", WBUS'(err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serdes_link_vc.md
# serdes_link_vc

Parametrised successor to the single-channel AXI serdes endpoint. It multiplexes NCH independent virtual-channel (VC) packet streams onto one outgoing serdes beat bus and demultiplexes the incoming bus back into per-VC streams. Flow control is per-VC and credit-based, replacing the single "fifo count < threshold" backpressure. It sits between the AXI protocol converters and the physical serdes lanes of the NoC.

## Interface
- WBUS, 72, serdes beat width: {payload, vc, kind[2:0]}
- NCH, 4, virtual channel count, at least 2
- CREDITS, 8, per-VC receive buffer depth, equal to the initial credit count
- CHW, $clog2(NCH), VC field width (derived)
- PW, WBUS-3-CHW, payload width (derived)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  NCH  per-VC beat offered
- tx_ready  out  NCH  per-VC beat accepted
- tx_kind  in  3*NCH  per-VC beat kind; must be non-zero when valid
- tx_data  in  PW*NCH  per-VC payload
- outgoing  out  WBUS  beat to serdes; kind==0 means idle
- credit_in  in  NCH  one-cycle credit-return pulses from the far end
- incoming  in  WBUS  beat from serdes; kind!=0 means valid
- credit_out  out  NCH  one-cycle credit-return pulses to the far end
- rx_valid  out  NCH  per-VC receive beat available
- rx_ready  in  NCH  per-VC receive pop
- rx_kind  out  3*NCH  kind of the head beat
- rx_data  out  PW*NCH  payload of the head beat
- err  out  1  sticky protocol-error flag

## Operation
- **TX credits.** Each VC has a counter of width $clog2(CREDITS+1), reset to CREDITS.
  - Decrement on a send; increment on credit_in[i]; both in the same cycle leaves it unchanged.
  - credit_in while the counter equals CREDITS saturates the counter and sets err.
- **TX arbitration.** Eligible VCs are those with tx_valid[i] and credit[i]>0. Round-robin selection starts at last_grant+1, with last_grant reset to NCH-1 so VC0 wins first.
  - tx_ready[i] is driven combinationally, at most one bit set per cycle.
  - A send is tx_valid[i] & tx_ready[i]. last_grant updates only on a send.
- **Outgoing register.** outgoing is a register with reset value 0.
  - On a send it loads {tx_data[i], i, tx_kind[i]}.
  - With no send, kind is 0. Payload and vc fields hold their previous values (don't-care).
  - There is no outgoing backpressure; credits guarantee acceptance downstream.
- **RX path.** One FIFO per VC, depth CREDITS, width PW+3.
  - An incoming beat with kind!=0 pushes {payload, kind} into FIFO[vc].
  - rx_valid[i] = !empty[i]. A pop is rx_valid[i] & rx_ready[i].
  - A pop causes credit_out[i] to pulse high for exactly one cycle, one cycle later.
- **Errors.** Each of the following sets err; err clears only on reset.
  - Credit overflow.
  - Push into a full FIFO; the beat is dropped.
  - Incoming vc >= NCH; the beat is dropped.
  - tx_valid with tx_kind==0; the beat is sent anyway, and the far end treats it as idle.
- **Reset values.** Reset clears all FIFOs and credit_out, restores credits to CREDITS, and clears err. Reset is asynchronous, so in-flight beats are lost; both link ends must reset together.

## Timing
- **TX latency.** Send in cycle N; beat on outgoing in cycle N+1 for exactly one cycle. Sustained throughput is one beat per cycle in aggregate.
- **Credit stall.** A VC with credit 0 sees tx_ready low. A credit_in in cycle N makes the VC eligible in cycle N+1.
- **RX latency.** Incoming beat sampled at edge N; rx_valid high in cycle N+1. Simultaneous push and pop on the same FIFO are legal, including when the FIFO is full.
- **Credit-return latency.** Pop in cycle N; credit_out pulse in cycle N+1. Pops on different VCs in the same cycle produce simultaneous pulses.

## Structure
- Shared package `serdes_pkg`:
  - kind encodings: 0=IDLE, 1=AR, 2=AW, 3=W, 4=R, 5=B
  - beat field offsets (KIND_LSB=0, VC_LSB=3)
  - err cause bit positions, for a future err_cause vector
- One sub-module, `syncfifo_sampled` (WID=PW+3, DEPTH=CREDITS), instantiated NCH times via generate.
- The round-robin arbiter is inline: a rotate, a priority pick, and an un-rotate.

## Test plan
- **Reset.** rst_n low mid-traffic → outgoing=0, credit_out=0, rx_valid=0, err=0, all credits=8 on release.
- **Round-robin.** VC0–VC3 always valid, credit_in looped back every beat → outgoing vc sequence 0,1,2,3,0,…; one beat per cycle, each one cycle after its send.
- **Credit exhaustion.** VC1 only valid, no credit_in → exactly 8 beats sent, then tx_ready[1]=0. One credit_in[1] pulse → exactly one more beat, sent in the next cycle.
- **RX buffering and credit return.** 8 beats into vc2 with rx_ready=0 → rx_valid[2]=1, no credit_out. Then rx_ready[2]=1 for 8 cycles → 8 payloads in order and 8 credit_out[2] pulses, each one cycle after its pop.
- **Simultaneous events.** credit_in[0] and a VC0 send in the same cycle → credit unchanged. A push and a pop on a full FIFO in the same cycle → no drop, err stays 0.
- **Error paths.** A 9th incoming beat to vc3 with rx_ready=0 → beat dropped, err=1. A credit_in[0] pulse at credit=8 → err=1, credit stays 8.
